// File: rtl/fft_digit_reverse_buf_if.sv
// Sample stream bundle between the last radix-4 butterfly stage, the
// digit-reverse buffer and its natural-order consumer.
interface fft_digit_reverse_buf_if #(
  parameter int WORDLENGTH_IO = 16,
  parameter int LOG4N         = 3
);
  logic                       enable;
  logic                       in_sop;
  logic [2*WORDLENGTH_IO-1:0] data_in;
  logic [2*WORDLENGTH_IO-1:0] data_out;
  logic                       out_valid;
  logic                       out_sop;
  logic [2*LOG4N-1:0]         out_index;

  modport master (
    output enable, in_sop, data_in,
    input  data_out, out_valid, out_sop, out_index
  );

  modport slave (
    input  enable, in_sop, data_in,
    output data_out, out_valid, out_sop, out_index
  );
endinterface

// File: rtl/fft_digit_reverse_buf.sv
// Ping-pong reorder buffer: writes base-4 digit-reversed frames at rev(k) and
// streams them back in natural bin order, one frame of latency.
module fft_digit_reverse_buf #(
  parameter int WORDLENGTH_IO = 16,
  parameter int LOG4N         = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  fft_digit_reverse_buf_if.slave   bus
);
  localparam int AW = 2*LOG4N;
  localparam int SW = 2*WORDLENGTH_IO;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  function automatic logic [AW-1:0] f_rev(input logic [AW-1:0] k);
    f_rev = '0;
    for (int i = 0; i < LOG4N; i++)
      f_rev[2*i +: 2] = k[2*(LOG4N-1-i) +: 2];
  endfunction

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_cnt, w_wr_cnt_nxt, w_wr_pos;
  logic            w_wr_en, w_frame_done;
  logic            r_wr_bank, r_rd_bank, r_rd_active;
  logic [1:0]      r_ready, w_ready_nxt;
  logic [AW-1:0]   r_rd_cnt;
  logic            w_rd_issue, w_rd_last;
  logic [SW-1:0]   w_rd_data;
  logic [SW-1:0]   r_data_out;
  logic            r_out_valid, r_out_sop;
  logic [AW-1:0]   r_out_index;
  logic [SW-1:0]   r_mem [0:2*(1<<AW)-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Write side: an in_sop outside position 0 restarts the frame in place.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_wr_pos     = r_wr_cnt;
    w_wr_en      = 1'b0;
    w_frame_done = 1'b0;
    if (bus.enable) begin
      if (r_state == S_IDLE) begin
        if (bus.in_sop) begin
          w_wr_en      = 1'b1;
          w_wr_pos     = '0;
          w_wr_cnt_nxt = AW'(1);
          w_state_nxt  = S_FILL;
        end
      end else begin
        w_wr_en = 1'b1;
        if (bus.in_sop && (r_wr_cnt != '0)) begin
          w_wr_pos     = '0;
          w_wr_cnt_nxt = AW'(1);
        end else begin
          w_wr_cnt_nxt = r_wr_cnt + AW'(1);
          w_frame_done = (r_wr_cnt == LAST);
        end
      end
    end
  end

  assign w_rd_issue = bus.enable && (r_rd_active || r_ready[r_rd_bank]);
  assign w_rd_last  = (r_rd_cnt == LAST);
  assign w_rd_data  = r_mem[{r_rd_bank, r_rd_cnt}];

  // Set is applied after clear so a forced collision on one bank keeps it ready.
  always_comb begin
    w_ready_nxt = r_ready;
    if (w_rd_issue && w_rd_last) w_ready_nxt[r_rd_bank] = 1'b0;
    if (w_frame_done)            w_ready_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[{r_wr_bank, f_rev(w_wr_pos)}] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_ready     <= 2'b00;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_rd_active <= 1'b0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_index <= '0;
    end else begin
      r_wr_cnt <= w_wr_cnt_nxt;
      r_ready  <= w_ready_nxt;
      if (w_frame_done) r_wr_bank <= ~r_wr_bank;
      if (w_rd_issue) begin
        r_data_out  <= w_rd_data;
        r_out_valid <= 1'b1;
        r_out_sop   <= (r_rd_cnt == '0);
        r_out_index <= r_rd_cnt;
        r_rd_cnt    <= r_rd_cnt + AW'(1);
        if (w_rd_last) begin
          r_rd_bank   <= ~r_rd_bank;
          r_rd_active <= r_ready[~r_rd_bank];
        end else begin
          r_rd_active <= 1'b1;
        end
      end else begin
        r_out_valid <= 1'b0;
        r_out_sop   <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_index = r_out_index;
endmodule
